// File: rtl/pixel_queue_pkg.sv
// Shared types for the pixel queue: screen limits, pixel record and queue FSM states.
package pixel_queue_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } t_pixel;

    typedef enum logic [1:0] {
        Q_RUN,
        Q_FLUSH,
        Q_DONE
    } e_queue_state;

endpackage

// File: rtl/pixel_queue_fifo_mem.sv
// Pixel storage for the queue: one write port, one asynchronous read port, no reset.
module pixel_fifo_mem
    import pixel_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  t_pixel        wdata,
    input  logic [AW-1:0] raddr,
    output t_pixel        rdata
);

    t_pixel mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_queue.sv
// Elastic, clipping pixel buffer between the drawing FSMs and the VGA adapter.
// Registered show-ahead head; done is forwarded only once every kept pixel has drained.
module pixel_queue #(
    parameter int DEPTH    = 16,
    parameter int SCREEN_W = pixel_queue_pkg::SCREEN_W,
    parameter int SCREEN_H = pixel_queue_pkg::SCREEN_H
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_plot,
    input  logic [7:0] in_x,
    input  logic [6:0] in_y,
    input  logic [2:0] in_colour,
    input  logic       in_done,
    output logic       in_ready,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    input  logic       out_ready,
    output logic       done,
    output logic [7:0] clip_count
);
    import pixel_queue_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [8:0] X_LIM = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

    e_queue_state  state;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] mem_cnt;
    t_pixel        head_q, in_px, rd_px;
    logic          plot_q, done_q;
    logic [7:0]    clip_q;

    logic push, on_screen, wr_en, clip_en, pop;
    logic mem_empty, head_load, bypass, mem_we, mem_rd;

    // count covers the head register plus the entries still in memory
    assign in_px     = '{x: in_x, y: in_y, c: in_colour};
    assign in_ready  = rst_n && (state == Q_RUN) && (count < CW'(DEPTH));
    assign push      = in_plot && in_ready;
    assign on_screen = ({1'b0, in_x} < X_LIM) && ({1'b0, in_y} < Y_LIM);
    assign wr_en     = push && on_screen;
    assign clip_en   = push && !on_screen;
    assign pop       = plot_q && out_ready;

    assign mem_cnt   = count - CW'(plot_q);
    assign mem_empty = (mem_cnt == '0);
    assign head_load = !plot_q || pop;
    // An empty queue forwards the incoming pixel straight into the head
    assign bypass    = head_load && mem_empty && wr_en;
    assign mem_we    = wr_en && !bypass;
    assign mem_rd    = head_load && !mem_empty;

    pixel_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (in_px),
        .raddr (rd_ptr),
        .rdata (rd_px)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
            plot_q <= 1'b0;
        end else begin
            count <= count + CW'(wr_en) - CW'(pop);
            if (mem_we) wr_ptr <= wr_ptr + 1'b1;
            if (mem_rd) begin
                head_q <= rd_px;
                rd_ptr <= rd_ptr + 1'b1;
                plot_q <= 1'b1;
            end else if (bypass) begin
                head_q <= in_px;
                plot_q <= 1'b1;
            end else if (head_load) begin
                plot_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= Q_RUN;
            done_q <= 1'b0;
            clip_q <= '0;
        end else begin
            if (clip_en && clip_q != 8'hFF) clip_q <= clip_q + 8'd1;
            case (state)
                Q_RUN: begin
                    if (in_done) state <= Q_FLUSH;
                end
                Q_FLUSH: begin
                    if (count == '0 && !plot_q) begin
                        state  <= Q_DONE;
                        done_q <= 1'b1;
                    end
                end
                Q_DONE: begin
                    if (!in_done) begin
                        state  <= Q_RUN;
                        done_q <= 1'b0;
                        clip_q <= '0;
                    end
                end
                default: state <= Q_RUN;
            endcase
        end
    end

    assign vga_x      = head_q.x;
    assign vga_y      = head_q.y;
    assign vga_colour = head_q.c;
    assign vga_plot   = plot_q;
    assign done       = done_q;
    assign clip_count = clip_q;

endmodule

// File: tb/tb_pixel_queue.sv
// Directed bench for pixel_queue with a scoreboard of expected on-screen pixels.
module tb_pixel_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_plot;
    logic [7:0] in_x;
    logic [6:0] in_y;
    logic [2:0] in_colour;
    logic       in_done;
    logic       in_ready;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       out_ready;
    logic       done;
    logic [7:0] clip_count;

    int          compared   = 0;
    int          mismatched = 0;
    int          exp_clip   = 0;
    int          popped     = 0;
    logic [17:0] sb [$];

    pixel_queue #(.DEPTH(16), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_plot    (in_plot),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .in_done    (in_done),
        .in_ready   (in_ready),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .out_ready  (out_ready),
        .done       (done),
        .clip_count (clip_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_timeout(input string tag);
        compared++;
        mismatched++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // Inputs are stable from #1 after a rising edge to the next one, so a
    // handshake seen at the falling edge is the one the DUT takes next edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && vga_plot === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $error("FAIL unexpected_pop: observed pixel %0h expected none",
                       {vga_x, vga_y, vga_colour});
            end else begin
                chk("pixel_order", 32'({vga_x, vga_y, vga_colour}), 32'(sb.pop_front()));
                popped++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_px(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        bit ok = 0;
        in_x = x; in_y = y; in_colour = c; in_plot = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1;
                if (x < 8'd160 && y < 7'd120) sb.push_back({x, y, c});
                else if (exp_clip < 255) exp_clip++;
            end
            tick();
        end
        in_plot = 1'b0;
        if (!ok) fail_timeout("push_accept");
    endtask

    task automatic wait_drain(input string tag);
        bit ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && vga_plot === 1'b0) ok = 1;
        end
        if (!ok) fail_timeout(tag);
        tick();
    endtask

    // Finish a frame: raise in_done, drain, check done timing, then restart.
    task automatic finish_frame(input string tag);
        bit ok = 0;
        in_done = 1'b1;
        tick();
        chk({tag, "_in_ready_flush"}, 32'(in_ready), 32'(0));
        chk({tag, "_done_low"}, 32'(done), 32'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && vga_plot === 1'b0) ok = 1;
        end
        if (!ok) fail_timeout({tag, "_drain"});
        chk({tag, "_done_not_early"}, 32'(done), 32'(0));
        @(negedge clk);
        chk({tag, "_done_high"}, 32'(done), 32'(1));
        tick();
        in_done = 1'b0;
        tick();
        exp_clip = 0;
        chk({tag, "_done_cleared"}, 32'(done), 32'(0));
        chk({tag, "_clip_cleared"}, 32'(clip_count), 32'(exp_clip));
        chk({tag, "_in_ready_run"}, 32'(in_ready), 32'(1));
    endtask

    initial begin
        int  base;
        bit  fill_done;
        rst_n = 1'b0; in_plot = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
        in_done = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_vga_plot", 32'(vga_plot), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_clip", 32'(clip_count), 32'(0));
        chk("rst_vga_xyc", 32'({vga_x, vga_y, vga_colour}), 32'(0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));

        // Latency and order with the adapter always ready
        out_ready = 1'b1;
        push_px(8'd3, 7'd4, 3'd5);
        chk("latency_plot", 32'(vga_plot), 32'(1));
        chk("latency_pixel", 32'({vga_x, vga_y, vga_colour}), 32'({8'd3, 7'd4, 3'd5}));
        push_px(8'd10, 7'd20, 3'd1);
        wait_drain("drain_two");

        // Fill to DEPTH under backpressure; held in_plot must not overwrite
        out_ready = 1'b0;
        base = popped;
        for (int i = 0; i < 16; i++) push_px(8'(i * 9), 7'(i + 1), 3'(i));
        chk("full_in_ready", 32'(in_ready), 32'(0));
        in_x = 8'd99; in_y = 7'd99; in_colour = 3'd6; in_plot = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_hold", 32'(in_ready), 32'(0));
        end
        in_plot = 1'b0;
        out_ready = 1'b1;
        wait_drain("drain_full");
        chk("full_count", 32'(popped - base), 32'(16));

        // No full-bypass: push and pop together at DEPTH refuses the push
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_px(8'(i), 7'(i * 7), 3'(7 - (i % 8)));
        in_x = 8'd77; in_y = 7'd77; in_colour = 3'd7; in_plot = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("no_full_bypass", 32'(in_ready), 32'(0));
        tick();
        in_plot = 1'b0;
        out_ready = 1'b0;
        chk("count_15_ready", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        wait_drain("drain_bypass");

        // Clip boundaries
        push_px(8'd159, 7'd119, 3'd7);
        push_px(8'd160, 7'd0, 3'd2);
        push_px(8'd0, 7'd120, 3'd3);
        push_px(8'd200, 7'd5, 3'd1);
        wait_drain("drain_clip");
        chk("clip_count_3", 32'(clip_count), 32'(exp_clip));

        // Saturation at 255
        for (int i = 0; i < 260; i++) push_px(8'd250, 7'(i), 3'd0);
        chk("clip_saturate", 32'(clip_count), 32'(exp_clip));

        // Frame end with 4 queued; in_plot ignored once flushing
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_px(8'(40 + i), 7'(50 + i), 3'(i + 2));
        in_done = 1'b1;
        tick();
        in_x = 8'd11; in_y = 7'd11; in_colour = 3'd1; in_plot = 1'b1;
        tick();
        chk("flush_in_ready", 32'(in_ready), 32'(0));
        chk("flush_done_low", 32'(done), 32'(0));
        in_plot = 1'b0;
        finish_frame("frame4");

        // Reset mid-stream with 5 queued
        out_ready = 1'b0;
        push_px(8'd170, 7'd1, 3'd1);
        for (int i = 0; i < 5; i++) push_px(8'(i + 1), 7'(i + 2), 3'(i + 3));
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_clip = 0;
        chk("midrst_vga_plot", 32'(vga_plot), 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_clip", 32'(clip_count), 32'(exp_clip));
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_ready_after", 32'(in_ready), 32'(1));
        chk("midrst_plot_after", 32'(vga_plot), 32'(0));
        out_ready = 1'b1;
        push_px(8'd1, 7'd2, 3'd3);
        wait_drain("drain_after_rst");

        // Full-screen fill with random backpressure
        base = popped;
        fill_done = 0;
        fork
            begin
                for (int y = 0; y < 120; y++)
                    for (int x = 0; x < 160; x++)
                        push_px(8'(x), 7'(y), 3'((x + y) % 8));
                fill_done = 1;
            end
            begin
                while (!fill_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        finish_frame("fill");
        chk("fill_count", 32'(popped - base), 32'(19200));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
